// File: rtl/axil_regfile_pkg.sv
// Shared definitions for the AXI-Lite register file.
//   - AXI response codes
//   - fixed word indices of the built-in registers
//   - byte-strobe merge helper (up to 64-bit data)
package axil_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned MAGIC_IDX   = 0;
  localparam int unsigned VER_IDX     = 1;
  localparam int unsigned SCRATCH_IDX = 2;
  localparam int unsigned USER_BASE   = 3;

  // Replace each byte of old_v whose strobe bit is set with the matching byte of new_v.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  strb);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_regfile_if.sv
// AXI-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
//   DATA_WIDTH : data bus width (32 or 64)
//   ADDR_WIDTH : address bus width carried on the bus
interface axi_lite #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_wr_hold.sv
// Write-beat holder: accepts AW and W independently, holds each beat, and
// raises commit for exactly one cycle once both are available.
//   awaddr/awvalid/awready : address beat (awready low while a beat is held)
//   wdata/wstrb/wvalid/wready : data beat (wready low while a beat is held)
//   b_pend  : a B response is outstanding (blocks a second commit)
//   b_done  : B handshake this cycle; releases both held beats
//   commit/cm_* : joint commit strobe with the merged address/data/strobes
module axil_wr_hold #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic                    b_pend,
  input  logic                    b_done,
  output logic                    commit,
  output logic [ADDR_WIDTH-1:0]   cm_addr,
  output logic [DATA_WIDTH-1:0]   cm_data,
  output logic [DATA_WIDTH/8-1:0] cm_strb
);

  logic                    aw_full_q, aw_full_d;
  logic                    w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
  logic                    aw_hs, w_hs;

  assign awready = !aw_full_q;
  assign wready  = !w_full_q;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      addr_d    = awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      data_d   = wdata;
      strb_d   = wstrb;
    end
    // Beats stay held through the B phase so the readys only reopen afterwards.
    if (b_done) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
  end

  // A beat arriving this cycle is used directly so commit does not wait a cycle.
  always_comb begin
    commit  = (aw_full_q || aw_hs) && (w_full_q || w_hs) && !b_pend;
    cm_addr = aw_full_q ? addr_q : awaddr;
    cm_data = w_full_q ? data_q : wdata;
    cm_strb = w_full_q ? strb_q : wstrb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
    end
  end

endmodule

// File: rtl/axil_regfile.sv
// AXI-Lite slave register file.
// Word map: 0 magic (RO), 1 version (RO), 2 scratch (RW),
//           3..3+NUM_RW-1 user RW, then NUM_RO user RO words; rest unmapped.
//   clk, rst_n   : clock, asynchronous active-low reset
//   s_axil       : AXI-Lite slave port
//   rw_reg       : user RW register contents, reg k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rw_wr_pulse  : one-cycle pulse the cycle after reg k is written
//   ro_reg       : user status inputs, sampled in the AR handshake cycle
module axil_regfile
  import axil_regfile_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] MAGIC_NUM  = 'h00114514,
  parameter logic [DATA_WIDTH-1:0] VERSION    = 'h00010000,
  parameter int unsigned           NUM_RW     = 4,
  parameter int unsigned           NUM_RO     = 4,
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] RW_RST     = '0,
  parameter logic [63:0]           ERR_DATA   = 64'hDEADBEEF
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  axi_lite.slave                                         s_axil,
  output logic [NUM_RW*DATA_WIDTH-1:0]                   rw_reg,
  output logic [NUM_RW-1:0]                              rw_wr_pulse,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] ro_reg
);

  localparam int unsigned AL = $clog2(DATA_WIDTH / 8);
  localparam int unsigned SB = DATA_WIDTH / 8;

  logic                  commit;
  logic [ADDR_WIDTH-1:0] cm_addr;
  logic [DATA_WIDTH-1:0] cm_data;
  logic [SB-1:0]         cm_strb;
  int unsigned           wr_idx, rd_idx;

  logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
  logic [DATA_WIDTH-1:0] rw_q [NUM_RW];
  logic [DATA_WIDTH-1:0] rw_d [NUM_RW];
  logic [NUM_RW-1:0]     pulse_q, pulse_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;
  logic                  ar_hs;

  axil_wr_hold #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .awaddr  (s_axil.awaddr[ADDR_WIDTH-1:0]),
    .awvalid (s_axil.awvalid),
    .awready (s_axil.awready),
    .wdata   (s_axil.wdata),
    .wstrb   (s_axil.wstrb),
    .wvalid  (s_axil.wvalid),
    .wready  (s_axil.wready),
    .b_pend  (bvalid_q),
    .b_done  (bvalid_q && s_axil.bready),
    .commit  (commit),
    .cm_addr (cm_addr),
    .cm_data (cm_data),
    .cm_strb (cm_strb)
  );

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_v,
                                                  input logic [DATA_WIDTH-1:0] new_v,
                                                  input logic [SB-1:0]         strb);
    logic [63:0] m;
    m = strb_merge(64'(old_v), 64'(new_v), 8'(strb));
    return m[DATA_WIDTH-1:0];
  endfunction

  assign wr_idx = 32'(cm_addr[ADDR_WIDTH-1:AL]);
  assign rd_idx = 32'(s_axil.araddr[ADDR_WIDTH-1:AL]);

  // Write path: only scratch and user RW words accept data; anything else is SLVERR.
  always_comb begin
    scratch_d = scratch_q;
    for (int k = 0; k < NUM_RW; k++) rw_d[k] = rw_q[k];
    pulse_d  = '0;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (bvalid_q && s_axil.bready) bvalid_d = 1'b0;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_SLVERR;
      if (wr_idx == SCRATCH_IDX) begin
        scratch_d = merge(scratch_q, cm_data, cm_strb);
        bresp_d   = RESP_OKAY;
      end
      for (int k = 0; k < NUM_RW; k++) begin
        if (wr_idx == USER_BASE + k) begin
          rw_d[k]    = merge(rw_q[k], cm_data, cm_strb);
          pulse_d[k] = 1'b1;
          bresp_d    = RESP_OKAY;
        end
      end
    end
  end

  // Read decode works on pre-write register state, so a same-cycle write is not visible.
  always_comb begin
    rd_data = ERR_DATA[DATA_WIDTH-1:0];
    rd_resp = RESP_SLVERR;
    if (rd_idx == MAGIC_IDX) begin
      rd_data = MAGIC_NUM;
      rd_resp = RESP_OKAY;
    end
    if (rd_idx == VER_IDX) begin
      rd_data = VERSION;
      rd_resp = RESP_OKAY;
    end
    if (rd_idx == SCRATCH_IDX) begin
      rd_data = scratch_q;
      rd_resp = RESP_OKAY;
    end
    for (int k = 0; k < NUM_RW; k++) begin
      if (rd_idx == USER_BASE + k) begin
        rd_data = rw_q[k];
        rd_resp = RESP_OKAY;
      end
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (rd_idx == USER_BASE + NUM_RW + k) begin
        rd_data = ro_reg[k*DATA_WIDTH +: DATA_WIDTH];
        rd_resp = RESP_OKAY;
      end
    end
  end

  assign ar_hs = s_axil.arvalid && !rvalid_q;

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rvalid_q && s_axil.rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_resp;
      rdata_d  = rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q <= '0;
      for (int k = 0; k < NUM_RW; k++) rw_q[k] <= RW_RST;
      pulse_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
      rvalid_q <= 1'b0;
      rresp_q  <= '0;
      rdata_q  <= '0;
    end else begin
      scratch_q <= scratch_d;
      for (int k = 0; k < NUM_RW; k++) rw_q[k] <= rw_d[k];
      pulse_q  <= pulse_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_RW; k++) rw_reg[k*DATA_WIDTH +: DATA_WIDTH] = rw_q[k];
  end

  assign rw_wr_pulse    = pulse_q;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = !rvalid_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rresp   = rresp_q;
  assign s_axil.rdata   = rdata_q;

endmodule

// File: tb/tb_axil_regfile.sv
module tb_axil_regfile;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [127:0] rw_reg;
  logic [3:0]   rw_wr_pulse;
  logic [127:0] ro_reg;

  axi_lite #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s_axil ();

  axil_regfile dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_axil      (s_axil),
    .rw_reg      (rw_reg),
    .rw_wr_pulse (rw_wr_pulse),
    .ro_reg      (ro_reg)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_b(input string tag);
    int n = 0;
    logic [1:0] e;
    while (!s_axil.bvalid && n < 20) begin step(); n++; end
    chk({tag, "_bvalid"}, 64'(s_axil.bvalid), 64'd1);
    e = bq.pop_front();
    chk({tag, "_bresp"}, 64'(s_axil.bresp), 64'(e));
  endtask

  task automatic check_r(input string tag);
    int n = 0;
    logic [33:0] e;
    while (!s_axil.rvalid && n < 20) begin step(); n++; end
    chk({tag, "_rvalid"}, 64'(s_axil.rvalid), 64'd1);
    e = rq.pop_front();
    chk({tag, "_rdata"}, 64'(s_axil.rdata), 64'(e[31:0]));
    chk({tag, "_rresp"}, 64'(s_axil.rresp), 64'(e[33:32]));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] resp, input string tag);
    logic aw_done = 1'b0, w_done = 1'b0, aw_now, w_now;
    int n = 0;
    s_axil.awaddr = a; s_axil.awvalid = 1'b1;
    s_axil.wdata = d; s_axil.wstrb = s; s_axil.wvalid = 1'b1;
    bq.push_back(resp);
    while (!(aw_done && w_done) && n < 20) begin
      aw_now = s_axil.awvalid && s_axil.awready;
      w_now  = s_axil.wvalid && s_axil.wready;
      step(); n++;
      if (aw_now) begin aw_done = 1'b1; s_axil.awvalid = 1'b0; end
      if (w_now)  begin w_done = 1'b1;  s_axil.wvalid = 1'b0; end
    end
    s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0;
    check_b(tag);
    step();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                         input string tag);
    logic done = 1'b0, now;
    int n = 0;
    s_axil.araddr = a; s_axil.arvalid = 1'b1;
    rq.push_back({resp, d});
    while (!done && n < 20) begin
      now = s_axil.arvalid && s_axil.arready;
      step(); n++;
      if (now) begin done = 1'b1; s_axil.arvalid = 1'b0; end
    end
    s_axil.arvalid = 1'b0;
    check_r(tag);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    s_axil.awaddr = '0; s_axil.awvalid = 1'b0;
    s_axil.wdata = '0; s_axil.wstrb = '0; s_axil.wvalid = 1'b0;
    s_axil.bready = 1'b1;
    s_axil.araddr = '0; s_axil.arvalid = 1'b0;
    s_axil.rready = 1'b1;
    ro_reg = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
    step(); step(); step();
    rst_n = 1'b1;
    step();

    // reset state
    chk("rst_awready", 64'(s_axil.awready), 64'd1);
    chk("rst_wready", 64'(s_axil.wready), 64'd1);
    chk("rst_arready", 64'(s_axil.arready), 64'd1);
    chk("rst_bvalid", 64'(s_axil.bvalid), 64'd0);
    chk("rst_rvalid", 64'(s_axil.rvalid), 64'd0);
    chk("rst_bresp", 64'(s_axil.bresp), 64'd0);
    chk("rst_rresp", 64'(s_axil.rresp), 64'd0);
    chk("rst_rdata", 64'(s_axil.rdata), 64'd0);
    chk("rst_rw_reg", 64'(rw_reg[63:0]), 64'd0);
    chk("rst_pulse", 64'(rw_wr_pulse), 64'd0);

    // fixed words and scratch
    do_read(32'h0, 32'h00114514, OKAY, "rd_magic");
    do_read(32'h4, 32'h00010000, OKAY, "rd_version");
    do_read(32'h8, 32'h0, OKAY, "rd_scratch0");
    do_write(32'h8, 32'hA5A5A5A5, 4'b0101, OKAY, "wr_scratch");
    do_read(32'h8, 32'h00A500A5, OKAY, "rd_scratch_strb");
    do_read(32'h1008, 32'h00A500A5, OKAY, "rd_scratch_alias");

    // W three cycles before AW
    bq.push_back(OKAY);
    s_axil.wdata = 32'h12345678; s_axil.wstrb = 4'hF; s_axil.wvalid = 1'b1;
    step();
    s_axil.wvalid = 1'b0;
    chk("wfirst_wready_low", 64'(s_axil.wready), 64'd0);
    step(); step();
    chk("wfirst_no_bvalid", 64'(s_axil.bvalid), 64'd0);
    chk("wfirst_no_pulse", 64'(rw_wr_pulse), 64'd0);
    s_axil.awaddr = 32'hC; s_axil.awvalid = 1'b1;
    step();
    s_axil.awvalid = 1'b0;
    chk("wfirst_bvalid_next", 64'(s_axil.bvalid), 64'd1);
    check_b("wfirst");
    chk("wfirst_rw0", 64'(rw_reg[31:0]), 64'h12345678);
    chk("wfirst_pulse", 64'(rw_wr_pulse), 64'b0001);
    chk("wfirst_awready_bcycle", 64'(s_axil.awready), 64'd0);
    step();
    chk("wfirst_pulse_gone", 64'(rw_wr_pulse), 64'd0);
    chk("wfirst_bvalid_gone", 64'(s_axil.bvalid), 64'd0);
    chk("wfirst_awready_back", 64'(s_axil.awready), 64'd1);
    chk("wfirst_wready_back", 64'(s_axil.wready), 64'd1);

    // zero-strobe write still pulses and leaves data unchanged
    bq.push_back(OKAY);
    s_axil.awaddr = 32'h18; s_axil.awvalid = 1'b1;
    s_axil.wdata = 32'hFFFFFFFF; s_axil.wstrb = 4'h0; s_axil.wvalid = 1'b1;
    step();
    s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0;
    chk("strb0_pulse", 64'(rw_wr_pulse), 64'b1000);
    check_b("strb0");
    chk("strb0_rw3", 64'(rw_reg[127:96]), 64'd0);
    step();

    // error responses and RO words
    do_write(32'h0, 32'hFFFFFFFF, 4'hF, SLVERR, "wr_magic");
    do_read(32'h0, 32'h00114514, OKAY, "rd_magic_kept");
    do_read(32'h100, 32'hDEADBEEF, SLVERR, "rd_unmapped");
    do_read(32'h1C, 32'hC0DE0000, OKAY, "rd_ro0");
    do_read(32'h28, 32'hC0DE0003, OKAY, "rd_ro3");
    do_read(32'h2C, 32'hDEADBEEF, SLVERR, "rd_past_ro");
    do_write(32'h1C, 32'h0, 4'hF, SLVERR, "wr_ro0");
    do_read(32'h10, 32'h0, OKAY, "rd_rw1");

    // backpressure with same-cycle write+read of scratch
    s_axil.bready = 1'b0; s_axil.rready = 1'b0;
    bq.push_back(OKAY);
    rq.push_back({OKAY, 32'h00A500A5});
    s_axil.awaddr = 32'h8; s_axil.awvalid = 1'b1;
    s_axil.wdata = 32'h11112222; s_axil.wstrb = 4'hF; s_axil.wvalid = 1'b1;
    s_axil.araddr = 32'h8; s_axil.arvalid = 1'b1;
    step();
    s_axil.wvalid = 1'b0;
    s_axil.awaddr = 32'h10; s_axil.araddr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_bvalid", 64'(s_axil.bvalid), 64'd1);
      chk("bp_rvalid", 64'(s_axil.rvalid), 64'd1);
      chk("bp_bresp", 64'(s_axil.bresp), 64'(OKAY));
      chk("bp_rdata", 64'(s_axil.rdata), 64'h00A500A5);
      chk("bp_awready", 64'(s_axil.awready), 64'd0);
      chk("bp_arready", 64'(s_axil.arready), 64'd0);
      step();
    end
    s_axil.awvalid = 1'b0; s_axil.arvalid = 1'b0;
    check_b("bp");
    check_r("bp");
    s_axil.bready = 1'b1; s_axil.rready = 1'b1;
    step();
    chk("bp_bvalid_done", 64'(s_axil.bvalid), 64'd0);
    chk("bp_rvalid_done", 64'(s_axil.rvalid), 64'd0);
    chk("bp_awready_back", 64'(s_axil.awready), 64'd1);
    chk("bp_arready_back", 64'(s_axil.arready), 64'd1);
    do_read(32'h8, 32'h11112222, OKAY, "rd_scratch_after_bp");

    // reset while B and R are pending
    s_axil.bready = 1'b0; s_axil.rready = 1'b0;
    s_axil.awaddr = 32'h8; s_axil.awvalid = 1'b1;
    s_axil.wdata = 32'hCAFEF00D; s_axil.wstrb = 4'hF; s_axil.wvalid = 1'b1;
    s_axil.araddr = 32'h0; s_axil.arvalid = 1'b1;
    step();
    s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0; s_axil.arvalid = 1'b0;
    chk("rstmid_bvalid_pend", 64'(s_axil.bvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_bvalid_async", 64'(s_axil.bvalid), 64'd0);
    chk("rstmid_rvalid_async", 64'(s_axil.rvalid), 64'd0);
    chk("rstmid_awready", 64'(s_axil.awready), 64'd1);
    chk("rstmid_rw0", 64'(rw_reg[31:0]), 64'd0);
    step();
    rst_n = 1'b1;
    s_axil.bready = 1'b1; s_axil.rready = 1'b1;
    step(); step();
    chk("rstmid_no_bvalid", 64'(s_axil.bvalid), 64'd0);
    chk("rstmid_no_rvalid", 64'(s_axil.rvalid), 64'd0);
    do_read(32'h8, 32'h0, OKAY, "rd_scratch_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axil_regfile.md
Name: axil_regfile

Overview:
Parametrised AXI-Lite slave register file; successor to the fixed single-magic-word check slave on the shell's check bus.
- Provides a read-only magic/ID word and a version word.
- Provides a scratch register, N user RW control registers and M user RO status registers.
- Supports byte strobes, error responses and per-register write pulses.
- Sits in the shell or role on any axi_lite slave port.

Parameters:
MAGIC_NUM, 'h00114514, value returned at word 0
VERSION, 'h00010000, value returned at word 1
NUM_RW, 4, user RW registers (1..64)
NUM_RO, 4, user RO registers (0..64)
DATA_WIDTH, 32, AXI-Lite data width (32 or 64)
ADDR_WIDTH, 12, significant address bits decoded
RW_RST, '0, reset value of every user RW register
ERR_DATA, 'hDEADBEEF, read data for unmapped addresses (truncated/zero-extended to DATA_WIDTH)

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
s_axil  axi_lite.slave  CHANNEL=1, DATA_WIDTH  AXI-Lite slave (AW/W/B/AR/R)
rw_reg  out  NUM_RW*DATA_WIDTH  user RW register contents, reg k at [k*DW +: DW]
rw_wr_pulse  out  NUM_RW  1-cycle pulse, the cycle after reg k is written
ro_reg  in  NUM_RO*DATA_WIDTH  user status inputs, sampled on read

Behaviour:
- Word index = addr[ADDR_WIDTH-1:log2(DW/8)]; low bits ignored; bits above ADDR_WIDTH ignored.
- Map: 0 magic (RO), 1 version (RO), 2 scratch (RW), 3..3+NUM_RW-1 user RW, next NUM_RO words user RO. All other words are unmapped.
- Reset state:
  - awready, wready, arready = 1; bvalid, rvalid = 0.
  - bresp, rresp, rdata = 0.
  - Scratch = 0, user RW = RW_RST, rw_wr_pulse = 0.
- Write channel, one outstanding transaction:
  - AW and W are accepted independently. Each ready drops after its handshake and the beat is held.
  - When both are held, commit in that cycle: apply wstrb bytewise and register bvalid=1 the next cycle.
  - AW+W in the same cycle: bvalid asserts 1 cycle later.
  - awready and wready re-assert after the B handshake, not in the B cycle.
- Write to RO or unmapped word: no state change, bresp=SLVERR (2'b10). Otherwise OKAY.
- rw_wr_pulse[k] fires on commit to reg k, even with wstrb=0.
- Read channel, one outstanding transaction:
  - AR handshake registers rdata/rresp; rvalid=1 the next cycle; arready=0 until the R handshake.
  - Unmapped read: rdata=ERR_DATA, rresp=SLVERR. RO/RW reads: OKAY.
- B and R hold their valid and payload stable until ready. Backpressure of any length is legal.
- Same-cycle write commit and AR to the same word: the read returns the pre-write value.
- Read and write paths are independent; both may complete in the same cycle.
- Asynchronous reset mid-transaction:
  - All held beats and pending responses are discarded; registers return to reset values.
  - No spurious bvalid/rvalid after reset release.
- ro_reg is sampled only in the AR handshake cycle; no synchroniser, the caller provides synchronous status.

Decomposition:
- Package axil_regfile_pkg: resp codes (OKAY, SLVERR), fixed word indices (MAGIC_IDX=0, VER_IDX=1, SCRATCH_IDX=2, USER_BASE=3), function for strobe merge.
- Sub-module axil_wr_hold: captures AW/W independently and presents a joint commit strobe. The read path stays inline.

Test Plan:
- After reset, read 0x0, 0x4 → rdata 0x00114514 OKAY, 0x00010000 OKAY; read 0x8 → 0.
- Write 0xA5A5A5A5 to 0x8 with wstrb 4'b0101, then read 0x8 → 0x00A500A5, bresp OKAY.
- W beat 3 cycles before AW to 0xC (data 0x12345678) → bvalid 1 cycle after AW; rw_reg[0]=0x12345678; rw_wr_pulse[0] one cycle.
- Write 0x0 and read 0x100 → bresp SLVERR with magic unchanged; rdata 0xDEADBEEF rresp SLVERR.
- Hold bready/rready low 10 cycles → B/R payload stable, no second AW/AR accepted; release → both complete, readys return.
- Assert rst_n low while bvalid pending → bvalid=0 immediately; scratch=0 on readback after release.
